ebus_responder: RTL
===================

# ebus_responder

Device-side EBUS responder: the controller end of the EBUS transaction that the EBOX initiates. It decodes controller select and function, handshakes with ack/xfer, and captures CONO/DATAO words. For CONI/DATAI/PI-address cycles it returns a word through its own EBUS driver slot. It also holds the device's PI assignment and drives the EBUS PI request lines. One instance sits inside each EBUS peripheral controller.

## Interface

Parameters:
- DEV_CS, 7'o0: controller select this device answers to.
- XFER_DELAY, 2: cycles from ack assertion to xfer assertion (1..15).

Ports:
- clk  in  1  system clock.
- CROBAR  in  1  reset, asynchronous, active-high.
- ebusCS  in  7  EBUS controller select.
- ebusFunc  in  3  EBUS function (tEBUSfunction encoding).
- ebusDemand  in  1  EBOX demand.
- ebusReset  in  1  EBUS reset, synchronous clear.
- ebusDataIn  in  36  EBUS data as seen by devices.
- ebusAck  out  1  acknowledge.
- ebusXfer  out  1  transfer done.
- ebusPI  out  8  PI request lines [0:7].
- ebusParity  out  1  parity of driven word.
- drvData  out  36  this device's EBUS driver data.
- drvDriving  out  1  this device's EBUS driver enable.
- coniStatus  in  36  device status word for CONI; bits 33:35 are replaced by the PIA.
- dataiWord  in  36  device word for DATAI.
- intReq  in  1  device interrupt request; a rising edge sets pending.
- intVector  in  36  word returned on PI address-in.
- conoWord  out  36  last CONO word.
- conoStrobe  out  1  one-cycle pulse when CONO completes.
- dataoWord  out  36  last DATAO word.
- dataoStrobe  out  1  one-cycle pulse when DATAO completes.

## Operation

- States: IDLE, ACK, XFER, HOLD.
- Device select match: ebusDemand & ebusCS==DEV_CS & func in {CONO, CONI, DATAO, DATAI}.
- PI select match: ebusDemand & pending & PIA!=0 & ebusCS[4:6]==PIA & func in {PIserved, PIaddrIn}.
- Other func codes (110, 111) are ignored.
- IDLE→ACK on either match. Latch the function; assert ebusAck.
- ACK: count XFER_DELAY cycles, then →XFER.
- XFER: assert ebusXfer for one cycle, then perform the function's action and →HOLD. Function actions:
  - CONO: capture ebusDataIn into conoWord; PIA ← ebusDataIn[33:35]; pulse conoStrobe.
  - DATAO: capture into dataoWord; pulse dataoStrobe.
  - CONI: drive {coniStatus[0:32], PIA}.
  - DATAI: drive dataiWord.
  - PIaddrIn: drive intVector.
  - PIserved: clear pending; drive nothing.
- HOLD: keep ebusAck, ebusXfer and the driver asserted until ebusDemand falls. Then deassert all of them and →IDLE.
- Demand drops in ACK: →IDLE, no strobe, no register update, pending unchanged.
- ebusPI[n] = pending & PIA==n, for n=1..7. ebusPI[0] is always 0.
- A new intReq rising edge in the same cycle as PIserved completion wins: pending stays set.
- ebusReset: PIA←0, pending←0, state→IDLE, all handshake outputs and the driver deasserted. conoWord and dataoWord are kept.
- drvData is 0 whenever drvDriving is 0.

## Timing

- Reset values of all outputs are 0. State→IDLE, PIA=0, pending=0.
- Demand is sampled at edge N → ebusAck high after edge N+1.
- ebusXfer, strobes and drvDriving go high XFER_DELAY cycles after ebusAck.
- Read data is registered in the same cycle drvDriving rises and is stable until it falls.
- Outputs fall one cycle after ebusDemand is sampled low.
- A new transaction needs at least one IDLE cycle. Demand held high in IDLE after completion is ignored until it deasserts.
- pending is set the cycle after the intReq rising edge is detected.
- CROBAR asynchronously clears everything mid-transaction.

## Configuration

- EBUS_PARITY_EN defined: ebusParity = odd parity over drvData while drvDriving, else 0.
- EBUS_PARITY_EN undefined: ebusParity is tied 0 and no parity logic exists.

## Test plan

- DEV_CS=7'o4, XFER_DELAY=2. CONO to CS 4 with data 36'o000000_000005 → ack after 1 cycle, xfer 2 cycles later, conoStrobe 1 cycle, PIA=5, outputs drop 1 cycle after demand falls.
- CONI to CS 4 with coniStatus=36'o123456_701230 and PIA=5 → drvDriving with data 36'o123456_701235. Same CONI to CS 5 → no ack.
- PIA=3, intReq pulse → ebusPI=8'b0001_0000. PIaddrIn with cs[4:6]=3 returns intVector. PIserved with cs[4:6]=3 clears pending → ebusPI=0.
- DATAO with demand dropped during ACK → no dataoStrobe, dataoWord unchanged, back to IDLE.
- ebusReset while in HOLD with pending set → all outputs 0, PIA=0, ebusPI=0. CROBAR mid-ACK has the same result.
- EBUS_PARITY_EN defined, DATAI with dataiWord=36'o000000_000001 → ebusParity=0. With dataiWord=36'o0 → ebusParity=1.

Source files
------------

// File: rtl/ebus_responder_if.sv
// EBUS signal bundle between the EBOX side (master) and one device responder (slave).
// Words use index 35-n for PDP-10 bit n; ebusPI uses index 7-n for PI level n.
interface ebus_responder_if;
    logic [6:0]  ebusCS;
    logic [2:0]  ebusFunc;
    logic        ebusDemand;
    logic        ebusReset;
    logic [35:0] ebusDataIn;
    logic        ebusAck;
    logic        ebusXfer;
    logic [7:0]  ebusPI;
    logic        ebusParity;
    logic [35:0] drvData;
    logic        drvDriving;

    modport master (
        output ebusCS, ebusFunc, ebusDemand, ebusReset, ebusDataIn,
        input  ebusAck, ebusXfer, ebusPI, ebusParity, drvData, drvDriving
    );

    modport slave (
        input  ebusCS, ebusFunc, ebusDemand, ebusReset, ebusDataIn,
        output ebusAck, ebusXfer, ebusPI, ebusParity, drvData, drvDriving
    );
endinterface

// File: rtl/ebus_responder.sv
// EBUS device-side responder: select decode, ack/xfer handshake, CONO/DATAO capture, read driver, PI.
// Optional EBUS_PARITY_EN adds odd parity over the driven word. PDP-10 bit n lives at index 35-n.
module ebus_responder #(
    parameter logic [6:0]  DEV_CS     = 7'o0,
    parameter int unsigned XFER_DELAY = 2
) (
    input  logic            clk,
    input  logic            CROBAR,
    ebus_responder_if.slave bus,
    input  logic [35:0]     coniStatus,
    input  logic [35:0]     dataiWord,
    input  logic            intReq,
    input  logic [35:0]     intVector,
    output logic [35:0]     conoWord,
    output logic            conoStrobe,
    output logic [35:0]     dataoWord,
    output logic            dataoStrobe
);
    localparam logic [2:0] FN_CONO       = 3'd0;
    localparam logic [2:0] FN_CONI       = 3'd1;
    localparam logic [2:0] FN_DATAO      = 3'd2;
    localparam logic [2:0] FN_DATAI      = 3'd3;
    localparam logic [2:0] FN_PI_SERVED  = 3'd4;
    localparam logic [2:0] FN_PI_ADDR_IN = 3'd5;
    localparam logic [3:0] DELAY_LAST    = 4'(XFER_DELAY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_XFER = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [2:0]  func_q, func_d;
    logic [6:0]  cs_q;
    logic [2:0]  fn_in_q;
    logic        demand_q;
    logic        wait_low_q, wait_low_d;
    logic        int_req_q, int_req_prev_q;
    logic        pending_q, pending_d;
    logic [2:0]  pia_q, pia_d;
    logic        ack_q, ack_d;
    logic        xfer_q, xfer_d;
    logic        drv_q, drv_d;
    logic [35:0] drv_data_q, drv_data_d;
    logic [35:0] cono_q, cono_d;
    logic [35:0] datao_q, datao_d;
    logic        cono_stb_q, cono_stb_d;
    logic        datao_stb_q, datao_stb_d;
    logic [7:0]  pi_q, pi_d;
    logic        dev_match_s, pi_match_s, int_rise_s, clear_pending_s, srst_s;

    // Bus inputs are registered once; this is the extra cycle before ack and before outputs fall.
    always_ff @(posedge clk or posedge CROBAR) begin
        if (CROBAR) begin
            demand_q       <= 1'b0;
            cs_q           <= 7'd0;
            fn_in_q        <= 3'd0;
            int_req_q      <= 1'b0;
            int_req_prev_q <= 1'b0;
        end else begin
            demand_q       <= bus.ebusDemand;
            cs_q           <= bus.ebusCS;
            fn_in_q        <= bus.ebusFunc;
            int_req_q      <= intReq;
            int_req_prev_q <= int_req_q;
        end
    end

    // Select decode and interrupt edge detect.
    always_comb begin
        dev_match_s = (cs_q == DEV_CS) && (fn_in_q[2] == 1'b0);
        pi_match_s  = pending_q && (pia_q != 3'd0) && (cs_q[2:0] == pia_q) &&
                      ((fn_in_q == FN_PI_SERVED) || (fn_in_q == FN_PI_ADDR_IN));
        int_rise_s  = int_req_q && !int_req_prev_q;
        srst_s      = bus.ebusReset;
    end

    // Handshake FSM next state, function actions and registered output values.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        func_d          = func_q;
        pia_d           = pia_q;
        ack_d           = ack_q;
        xfer_d          = xfer_q;
        drv_d           = drv_q;
        drv_data_d      = drv_data_q;
        cono_d          = cono_q;
        datao_d         = datao_q;
        cono_stb_d      = 1'b0;
        datao_stb_d     = 1'b0;
        clear_pending_s = 1'b0;

        if (demand_q) begin
            wait_low_d = wait_low_q;
        end else begin
            wait_low_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (demand_q && !wait_low_q && (dev_match_s || pi_match_s)) begin
                    state_d = ST_ACK;
                    cnt_d   = 4'd0;
                    func_d  = fn_in_q;
                    ack_d   = 1'b1;
                end else begin
                    ack_d      = 1'b0;
                    xfer_d     = 1'b0;
                    drv_d      = 1'b0;
                    drv_data_d = 36'd0;
                end
            end
            ST_ACK: begin
                if (!demand_q) begin
                    // Abandoned before the transfer: nothing is captured or driven.
                    state_d = ST_IDLE;
                    ack_d   = 1'b0;
                end else if (cnt_q == DELAY_LAST) begin
                    state_d = ST_XFER;
                    xfer_d  = 1'b1;
                    case (func_q)
                        FN_CONO: begin
                            cono_d     = bus.ebusDataIn;
                            pia_d      = bus.ebusDataIn[2:0];
                            cono_stb_d = 1'b1;
                        end
                        FN_DATAO: begin
                            datao_d     = bus.ebusDataIn;
                            datao_stb_d = 1'b1;
                        end
                        FN_CONI: begin
                            drv_d      = 1'b1;
                            drv_data_d = (coniStatus & ~36'o7) | {33'd0, pia_q};
                        end
                        FN_DATAI: begin
                            drv_d      = 1'b1;
                            drv_data_d = dataiWord;
                        end
                        FN_PI_ADDR_IN: begin
                            drv_d      = 1'b1;
                            drv_data_d = intVector;
                        end
                        FN_PI_SERVED: begin
                            clear_pending_s = 1'b1;
                        end
                        default: begin
                            drv_d = 1'b0;
                        end
                    endcase
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_XFER, ST_HOLD: begin
                if (!demand_q) begin
                    state_d    = ST_IDLE;
                    ack_d      = 1'b0;
                    xfer_d     = 1'b0;
                    drv_d      = 1'b0;
                    drv_data_d = 36'd0;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                ack_d      = 1'b0;
                xfer_d     = 1'b0;
                drv_d      = 1'b0;
                drv_data_d = 36'd0;
            end
        endcase

        // A fresh request arriving with the PI-served completion keeps pending set.
        if (int_rise_s) begin
            pending_d = 1'b1;
        end else if (clear_pending_s) begin
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q;
        end

        if (pending_d && (pia_d != 3'd0)) begin
            pi_d = 8'h80 >> pia_d;
        end else begin
            pi_d = 8'h00;
        end
    end

    // State and output registers; ebusReset clears everything except the captured words.
    always_ff @(posedge clk or posedge CROBAR) begin
        if (CROBAR) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            func_q      <= 3'd0;
            wait_low_q  <= 1'b0;
            pending_q   <= 1'b0;
            pia_q       <= 3'd0;
            ack_q       <= 1'b0;
            xfer_q      <= 1'b0;
            drv_q       <= 1'b0;
            drv_data_q  <= 36'd0;
            cono_q      <= 36'd0;
            datao_q     <= 36'd0;
            cono_stb_q  <= 1'b0;
            datao_stb_q <= 1'b0;
            pi_q        <= 8'd0;
        end else if (srst_s) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            func_q      <= 3'd0;
            wait_low_q  <= 1'b1;
            pending_q   <= 1'b0;
            pia_q       <= 3'd0;
            ack_q       <= 1'b0;
            xfer_q      <= 1'b0;
            drv_q       <= 1'b0;
            drv_data_q  <= 36'd0;
            cono_stb_q  <= 1'b0;
            datao_stb_q <= 1'b0;
            pi_q        <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            func_q      <= func_d;
            wait_low_q  <= wait_low_d;
            pending_q   <= pending_d;
            pia_q       <= pia_d;
            ack_q       <= ack_d;
            xfer_q      <= xfer_d;
            drv_q       <= drv_d;
            drv_data_q  <= drv_data_d;
            cono_q      <= cono_d;
            datao_q     <= datao_d;
            cono_stb_q  <= cono_stb_d;
            datao_stb_q <= datao_stb_d;
            pi_q        <= pi_d;
        end
    end

`ifdef EBUS_PARITY_EN
    function automatic logic odd_parity(input logic [35:0] word);
        return ~(^word);
    endfunction

    logic parity_q, parity_d;

    // Parity is computed from the word being registered so it lines up with drvData.
    always_comb begin
        if (drv_d) begin
            parity_d = odd_parity(drv_data_d);
        end else begin
            parity_d = 1'b0;
        end
    end

    // Parity register.
    always_ff @(posedge clk or posedge CROBAR) begin
        if (CROBAR) begin
            parity_q <= 1'b0;
        end else if (srst_s) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign bus.ebusParity = parity_q;
`else
    assign bus.ebusParity = 1'b0;
`endif

    assign bus.ebusAck    = ack_q;
    assign bus.ebusXfer   = xfer_q;
    assign bus.ebusPI     = pi_q;
    assign bus.drvData    = drv_data_q;
    assign bus.drvDriving = drv_q;
    assign conoWord       = cono_q;
    assign conoStrobe     = cono_stb_q;
    assign dataoWord      = datao_q;
    assign dataoStrobe    = datao_stb_q;
endmodule
